divider: RTL and testbench



---
 rtl/divider_pkg.sv | 19 +
 rtl/divider_negate.sv | 15 +
 rtl/divider.sv | 166 ++++++++++++++++
 tb/tb_divider.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared definitions for the M-extension divider: widths, FSM encoding and
// the fixed RISC-V results for divide-by-zero and signed overflow.
package divider_pkg;

  localparam int unsigned DATA_LEN         = 32;
  localparam int unsigned MD_OUT_SEL_WIDTH = 2;
  localparam int unsigned DIV_CNT_W        = $clog2(DATA_LEN);

  typedef enum logic [1:0] {
    DIV_ST_IDLE = 2'd0,
    DIV_ST_CALC = 2'd1,
    DIV_ST_SIGN = 2'd2,
    DIV_ST_DONE = 2'd3
  } div_state_e;

  localparam logic [DATA_LEN-1:0] DIV_ZERO_QUOT = '1;
  localparam logic [DATA_LEN-1:0] DIV_OVF_QUOT  = {1'b1, {(DATA_LEN-1){1'b0}}};

endpackage

// File: rtl/divider_negate.sv
// Conditional two's-complement negation, used for operand magnitudes and for
// the sign corrections of quotient and remainder.
module div_negate
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_LEN
) (
  input  logic             neg_i,
  input  logic [WIDTH-1:0] val_i,
  output logic [WIDTH-1:0] val_o
);

  assign val_o = neg_i ? -val_i : val_i;

endmodule

// File: rtl/divider.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Define DIV_FAST_PATH_EN to finish divide-by-zero and signed overflow in one cycle.
module divider
  import divider_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        flush,
  input  logic [DATA_LEN-1:0]         src1,
  input  logic [DATA_LEN-1:0]         src2,
  input  logic                        div_signed,
  input  logic [MD_OUT_SEL_WIDTH-1:0] md_out_sel,
  output logic                        busy,
  output logic                        result_valid,
  output logic [DATA_LEN-1:0]         result
);

  div_state_e            state_q, state_d;
  logic [DATA_LEN-1:0]   quo_q, quo_d;
  logic [DATA_LEN-1:0]   dvsr_q, dvsr_d;
  logic [DATA_LEN-1:0]   rem_q, rem_d;
  logic [DIV_CNT_W-1:0]  cnt_q, cnt_d;
  logic                  signed_q, signed_d;
  logic                  rem_sel_q, rem_sel_d;
  logic                  dvnd_neg_q, dvnd_neg_d;
  logic                  dvsr_neg_q, dvsr_neg_d;
  logic                  dz_q, dz_d;
  logic                  ovf_q, ovf_d;
  logic [DATA_LEN-1:0]   result_q, result_d;

  logic                  src1_neg, src2_neg;
  logic [DATA_LEN-1:0]   src1_abs, src2_abs;
  logic                  is_dz, is_ovf;
  logic [DATA_LEN:0]     shift_rem, trial;
  logic                  q_bit;
  logic                  quo_neg, rem_neg;
  logic [DATA_LEN-1:0]   quo_fixed, rem_fixed;
  logic [DATA_LEN-1:0]   quo_final, rem_final;
  logic                  sel_unused;

  assign sel_unused = |(md_out_sel >> 1);

  assign src1_neg = div_signed & src1[DATA_LEN-1];
  assign src2_neg = div_signed & src2[DATA_LEN-1];

  div_negate #(.WIDTH(DATA_LEN)) u_abs_src1 (.neg_i(src1_neg), .val_i(src1), .val_o(src1_abs));
  div_negate #(.WIDTH(DATA_LEN)) u_abs_src2 (.neg_i(src2_neg), .val_i(src2), .val_o(src2_abs));

  assign is_dz  = (src2 == '0);
  assign is_ovf = div_signed & (src1 == DIV_OVF_QUOT) & (src2 == '1);

  // Dividend bits are consumed from the top of quo_q while quotient bits enter at the bottom.
  assign shift_rem = {rem_q, quo_q[DATA_LEN-1]};
  assign trial     = shift_rem - {1'b0, dvsr_q};
  assign q_bit     = ~trial[DATA_LEN];

  assign quo_neg = signed_q & (dvnd_neg_q ^ dvsr_neg_q);
  assign rem_neg = signed_q & dvnd_neg_q;

  div_negate #(.WIDTH(DATA_LEN)) u_fix_quo (.neg_i(quo_neg), .val_i(quo_q), .val_o(quo_fixed));
  div_negate #(.WIDTH(DATA_LEN)) u_fix_rem (.neg_i(rem_neg), .val_i(rem_q), .val_o(rem_fixed));

  // With a zero divisor every trial succeeds, so the corrected remainder is already src1.
  assign quo_final = ovf_q ? DIV_OVF_QUOT : (dz_q ? DIV_ZERO_QUOT : quo_fixed);
  assign rem_final = ovf_q ? '0 : rem_fixed;

  always_comb begin
    state_d    = state_q;
    quo_d      = quo_q;
    dvsr_d     = dvsr_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    signed_d   = signed_q;
    rem_sel_d  = rem_sel_q;
    dvnd_neg_d = dvnd_neg_q;
    dvsr_neg_d = dvsr_neg_q;
    dz_d       = dz_q;
    ovf_d      = ovf_q;
    result_d   = result_q;

    case (state_q)
      DIV_ST_IDLE: begin
        if (start) begin
          signed_d   = div_signed;
          rem_sel_d  = md_out_sel[0];
          dvnd_neg_d = src1[DATA_LEN-1];
          dvsr_neg_d = src2[DATA_LEN-1];
          quo_d      = src1_abs;
          dvsr_d     = src2_abs;
          rem_d      = '0;
          cnt_d      = DIV_CNT_W'(DATA_LEN - 1);
          dz_d       = is_dz;
          ovf_d      = is_ovf;
          state_d    = DIV_ST_CALC;
`ifdef DIV_FAST_PATH_EN
          if (is_dz || is_ovf) begin
            state_d  = DIV_ST_DONE;
            result_d = md_out_sel[0] ? (is_dz ? src1 : '0)
                                     : (is_dz ? DIV_ZERO_QUOT : DIV_OVF_QUOT);
          end
`endif
        end
      end
      DIV_ST_CALC: begin
        quo_d = {quo_q[DATA_LEN-2:0], q_bit};
        rem_d = q_bit ? trial[DATA_LEN-1:0] : shift_rem[DATA_LEN-1:0];
        if (cnt_q == '0) begin
          state_d = DIV_ST_SIGN;
        end else begin
          cnt_d = cnt_q - DIV_CNT_W'(1);
        end
      end
      DIV_ST_SIGN: begin
        result_d = rem_sel_q ? rem_final : quo_final;
        state_d  = DIV_ST_DONE;
      end
      DIV_ST_DONE: begin
        state_d = DIV_ST_IDLE;
      end
      default: begin
        state_d = DIV_ST_IDLE;
      end
    endcase

    if (flush) begin
      state_d  = DIV_ST_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= DIV_ST_IDLE;
      quo_q      <= '0;
      dvsr_q     <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      signed_q   <= 1'b0;
      rem_sel_q  <= 1'b0;
      dvnd_neg_q <= 1'b0;
      dvsr_neg_q <= 1'b0;
      dz_q       <= 1'b0;
      ovf_q      <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      quo_q      <= quo_d;
      dvsr_q     <= dvsr_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      signed_q   <= signed_d;
      rem_sel_q  <= rem_sel_d;
      dvnd_neg_q <= dvnd_neg_d;
      dvsr_neg_q <= dvsr_neg_d;
      dz_q       <= dz_d;
      ovf_q      <= ovf_d;
      result_q   <= result_d;
    end
  end

  assign busy         = (state_q != DIV_ST_IDLE);
  assign result_valid = (state_q == DIV_ST_DONE) && !flush;
  assign result       = result_q;

endmodule

// File: tb/tb_divider.sv
// Directed bench for the divider: arithmetic results, latency, flush and reset behaviour.
`timescale 1ns/1ps
module tb_divider;

`ifdef DIV_FAST_PATH_EN
  localparam int SP_LAT = 1;
`else
  localparam int SP_LAT = 34;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        div_signed;
  logic [1:0]  md_out_sel;
  logic        busy;
  logic        result_valid;
  logic [31:0] result;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  divider dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .flush        (flush),
    .src1         (src1),
    .src2         (src2),
    .div_signed   (div_signed),
    .md_out_sel   (md_out_sel),
    .busy         (busy),
    .result_valid (result_valid),
    .result       (result)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; start is sampled on the next rising edge (edge 0).
  task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sgn, input logic [1:0] sel, input logic [31:0] exp_res,
                        input int exp_lat, input int poke);
    int   lat;
    logic busy_ok;
    src1 = a; src2 = b; div_signed = sgn; md_out_sel = sel; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; src1 = 32'd200; src2 = 32'd3; div_signed = 1'b0; md_out_sel = 2'b00;
    lat = 0;
    busy_ok = 1'b1;
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (result_valid === 1'b1) lat = c;
      else begin
        start = (c == poke);
        @(negedge clk);
      end
    end
    start = 1'b0;
    chk({tag, " result"}, result, exp_res);
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " busy"}, {31'd0, busy_ok}, 32'd1);
    @(negedge clk);
    chk({tag, " idle"}, {30'd0, busy, result_valid}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic seen;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0;
    src1 = '0; src2 = '0; div_signed = 1'b0; md_out_sel = 2'b00;
    repeat (2) @(negedge clk);
    chk("reset result", result, 32'd0);
    chk("reset flags", {30'd0, busy, result_valid}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("after reset flags", {30'd0, busy, result_valid}, 32'd0);

    do_div("s 100/7",        32'd100,      32'd7,        1'b1, 2'b00, 32'd14,       34, 0);
    do_div("s 100%7",        32'd100,      32'd7,        1'b1, 2'b01, 32'd2,        34, 0);
    do_div("s -7/2",         32'hFFFFFFF9, 32'd2,        1'b1, 2'b00, 32'hFFFFFFFD, 34, 0);
    do_div("s -7%2",         32'hFFFFFFF9, 32'd2,        1'b1, 2'b11, 32'hFFFFFFFF, 34, 0);
    do_div("u ffffffff/2",   32'hFFFFFFFF, 32'd2,        1'b0, 2'b00, 32'h7FFFFFFF, 34, 0);
    do_div("u 8000.../ff.../", 32'h80000000, 32'hFFFFFFFF, 1'b0, 2'b00, 32'd0,      34, 0);
    do_div("u 8000...%ff...",  32'h80000000, 32'hFFFFFFFF, 1'b0, 2'b01, 32'h80000000, 34, 0);
    do_div("s 5/0",          32'd5,        32'd0,        1'b1, 2'b00, 32'hFFFFFFFF, SP_LAT, 0);
    do_div("s 5%0",          32'd5,        32'd0,        1'b1, 2'b01, 32'd5,        SP_LAT, 0);
    do_div("u 5/0",          32'd5,        32'd0,        1'b0, 2'b00, 32'hFFFFFFFF, SP_LAT, 0);
    do_div("u 5%0",          32'd5,        32'd0,        1'b0, 2'b01, 32'd5,        SP_LAT, 0);
    do_div("s -5/0",         32'hFFFFFFFB, 32'd0,        1'b1, 2'b00, 32'hFFFFFFFF, SP_LAT, 0);
    do_div("s -5%0",         32'hFFFFFFFB, 32'd0,        1'b1, 2'b01, 32'hFFFFFFFB, SP_LAT, 0);
    do_div("s ovf div",      32'h80000000, 32'hFFFFFFFF, 1'b1, 2'b00, 32'h80000000, SP_LAT, 0);
    do_div("s ovf rem",      32'h80000000, 32'hFFFFFFFF, 1'b1, 2'b01, 32'd0,        SP_LAT, 0);
    do_div("s -100/7",       32'hFFFFFF9C, 32'd7,        1'b1, 2'b00, 32'hFFFFFFF2, 34, 0);
    do_div("s -100%7",       32'hFFFFFF9C, 32'd7,        1'b1, 2'b01, 32'hFFFFFFFE, 34, 0);

    // Flush at cycle 10, flush+start at cycle 11, fresh start at cycle 12.
    src1 = 32'd100; src2 = 32'd7; div_signed = 1'b1; md_out_sel = 2'b00; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int c = 1; c < 10; c++) begin
      if (result_valid === 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    chk("flush busy c10", {31'd0, busy}, 32'd1);
    if (result_valid === 1'b1) seen = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    if (result_valid === 1'b1) seen = 1'b1;
    chk("flush busy c11", {31'd0, busy}, 32'd0);
    chk("flush result hold", result, 32'hFFFFFFFE);
    start = 1'b1;
    @(negedge clk);
    if (result_valid === 1'b1) seen = 1'b1;
    chk("flush beats start", {31'd0, busy}, 32'd0);
    chk("flush no valid", {31'd0, seen}, 32'd0);
    flush = 1'b0;
    start = 1'b0;
    do_div("restart 100/7",  32'd100,      32'd7,        1'b1, 2'b00, 32'd14,       34, 0);

    do_div("busy start ign", 32'd100,      32'd7,        1'b1, 2'b00, 32'd14,       34, 5);

    // Asynchronous reset in the middle of CALC.
    src1 = 32'd100; src2 = 32'd7; div_signed = 1'b1; md_out_sel = 2'b01; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre-reset busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid reset result", result, 32'd0);
    chk("mid reset flags", {30'd0, busy, result_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_div("post-reset 100%7", 32'd100,    32'd7,        1'b1, 2'b01, 32'd2,        34, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
